// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the ACC_C offload protocol endpoint.
//   - AccNumReq / AccDataWidth / AccIdWidth : default system sizing
//   - idx_width / acc_id_width             : extended ID width derivation
//   - acc_c_req_chan_t / acc_c_rsp_chan_t  : request / response channel bundles
// ---------------------------------------------------------------------------
package acc_pkg;

  // Width of an index able to address n requesters; a single requester
  // still needs one bit so the ID field never collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Extended ID = one routing bit plus the requester index.
  function automatic int acc_id_width(input int numReq);
    return 1 + idx_width(numReq);
  endfunction

  localparam int AccNumReq    = 2;
  localparam int AccDataWidth = 32;
  localparam int AccIdWidth   = acc_id_width(AccNumReq);

  typedef struct packed {
    logic [31:0]                   instr;
    logic [2:0][AccDataWidth-1:0]  rs;
    logic [AccIdWidth-1:0]         id;
  } acc_c_req_chan_t;

  typedef struct packed {
    logic [AccDataWidth-1:0] data;
    logic                    error;
    logic [AccIdWidth-1:0]   id;
  } acc_c_rsp_chan_t;

endpackage

// File: rtl/acc_c_responder_if.sv
// ---------------------------------------------------------------------------
// acc_c_responder_if
// Interconnect-side request/response bus of the ACC_C responder.
//   q_* : request channel (valid/ready, instruction, operands rs1..rs3, ID)
//   p_* : response channel (valid/ready, result data, error flag, echoed ID)
// Modports:
//   master : interconnect side, drives requests and consumes responses
//   slave  : responder side, accepts requests and drives responses
// ---------------------------------------------------------------------------
interface acc_c_responder_if
  import acc_pkg::*;
#(
  parameter int DataWidth = AccDataWidth,
  parameter int IdWidth   = AccIdWidth
);

  logic                       q_valid_i;
  logic                       q_ready_o;
  logic [31:0]                q_instr_i;
  logic [2:0][DataWidth-1:0]  q_rs_i;
  logic [IdWidth-1:0]         q_id_i;

  logic                       p_valid_o;
  logic                       p_ready_i;
  logic [DataWidth-1:0]       p_data_o;
  logic                       p_error_o;
  logic [IdWidth-1:0]         p_id_o;

  modport master (
    output q_valid_i, q_instr_i, q_rs_i, q_id_i, p_ready_i,
    input  q_ready_o, p_valid_o, p_data_o, p_error_o, p_id_o
  );

  modport slave (
    input  q_valid_i, q_instr_i, q_rs_i, q_id_i, p_ready_i,
    output q_ready_o, p_valid_o, p_data_o, p_error_o, p_id_o
  );

endinterface

// File: rtl/acc_id_fifo.sv
// ---------------------------------------------------------------------------
// acc_id_fifo
// Synchronous FIFO holding the extended IDs of accepted requests.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, clears pointers and count
//   push_i  : write data_i at the tail
//   data_i  : ID to store
//   pop_i   : drop the head entry
//   head_o  : oldest stored ID
//   count_o : number of stored entries (0..Depth)
// Empty/full are judged by the caller from count_o; push on full or pop on
// empty is the caller's responsibility to avoid.
// ---------------------------------------------------------------------------
module acc_id_fifo #(
  parameter int  Depth    = 4,
  parameter int  Width    = 2,
  localparam int CntWidth = $clog2(Depth + 1),
  localparam int PtrWidth = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    head_o,
  output logic [CntWidth-1:0] count_o
);

  logic [Width-1:0]    r_mem [Depth];
  logic [PtrWidth-1:0] r_wrPtr;
  logic [PtrWidth-1:0] r_rdPtr;
  logic [CntWidth-1:0] r_count;

  // Storage has no reset: an entry is only ever read after it was written,
  // because the count gates every pop.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  // Pointers wrap naturally since Depth is a power of two. A simultaneous
  // push and pop moves both pointers and leaves the count untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push_i) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (pop_i) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (push_i && !pop_i) begin
        r_count <= r_count + 1'b1;
      end else if (pop_i && !push_i) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign head_o  = r_mem[r_rdPtr];
  assign count_o = r_count;

endmodule

// File: rtl/acc_c_responder.sv
// ---------------------------------------------------------------------------
// acc_c_responder
// Accelerator-side endpoint of the ACC_C offload protocol. Requests from the
// interconnect pass straight through to an in-order accelerator core while
// their extended IDs are queued; each core result is registered together with
// the oldest queued ID so the interconnect can route it back.
//   clk_i / rst_i      : clock, synchronous active-high reset
//   bus (slave)        : interconnect q_*/p_* channels
//   core_req_*         : request to the core (valid/ready, instr, rs)
//   core_rsp_*         : result from the core (valid/ready, data, error)
//   outstanding_o      : number of accepted requests awaiting a result
//   orphan_err_o       : sticky, a core result arrived with no queued ID
// ---------------------------------------------------------------------------
module acc_c_responder
  import acc_pkg::*;
#(
  parameter int  DataWidth      = AccDataWidth,
  parameter int  IdWidth        = AccIdWidth,
  parameter int  MaxOutstanding = 4,
  localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  acc_c_responder_if.slave          bus,
  output logic                      core_req_valid_o,
  input  logic                      core_req_ready_i,
  output logic [31:0]               core_instr_o,
  output logic [2:0][DataWidth-1:0] core_rs_o,
  input  logic                      core_rsp_valid_i,
  output logic                      core_rsp_ready_o,
  input  logic [DataWidth-1:0]      core_rsp_data_i,
  input  logic                      core_rsp_error_i,
  output logic [CntWidth-1:0]       outstanding_o,
  output logic                      orphan_err_o
);

  logic [CntWidth-1:0]  w_count;
  logic [IdWidth-1:0]   w_headId;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_coreFire;
  logic                 w_pop;
  logic                 w_orphan;

  logic                 r_pValid;
  logic [DataWidth-1:0] r_pData;
  logic                 r_pError;
  logic [IdWidth-1:0]   r_pId;
  logic                 r_orphan;

  // Request side is purely combinational. Full blocks acceptance even if a
  // pop happens in the same cycle, so p_ready_i never reaches q_ready_o.
  assign w_full           = (w_count == CntWidth'(MaxOutstanding));
  assign w_empty          = (w_count == '0);
  assign core_req_valid_o = bus.q_valid_i & ~w_full;
  assign bus.q_ready_o    = core_req_ready_i & ~w_full;
  assign core_instr_o     = bus.q_instr_i;
  assign core_rs_o        = bus.q_rs_i;
  assign w_push           = bus.q_valid_i & bus.q_ready_o;

  // A result is taken whenever the output register is free or draining.
  // With nothing queued the result has no destination and is discarded.
  assign core_rsp_ready_o = ~r_pValid | bus.p_ready_i;
  assign w_coreFire       = core_rsp_valid_i & core_rsp_ready_o;
  assign w_pop            = w_coreFire & ~w_empty;
  assign w_orphan         = w_coreFire & w_empty;

  acc_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdWidth)
  ) u_idFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (bus.q_id_i),
    .pop_i   (w_pop),
    .head_o  (w_headId),
    .count_o (w_count)
  );

  // Response register: load a new result together with the FIFO head, hold
  // everything under backpressure, and drop valid once the result is taken
  // with nothing new behind it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pValid <= 1'b0;
      r_pData  <= '0;
      r_pError <= 1'b0;
      r_pId    <= '0;
    end else if (w_pop) begin
      r_pValid <= 1'b1;
      r_pData  <= core_rsp_data_i;
      r_pError <= core_rsp_error_i;
      r_pId    <= w_headId;
    end else if (bus.p_ready_i) begin
      r_pValid <= 1'b0;
    end
  end

  // Orphan flag stays set until reset so software can spot a core that
  // produced more results than it was given requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_orphan <= 1'b0;
    end else if (w_orphan) begin
      r_orphan <= 1'b1;
    end
  end

  assign bus.p_valid_o = r_pValid;
  assign bus.p_data_o  = r_pData;
  assign bus.p_error_o = r_pError;
  assign bus.p_id_o    = r_pId;
  assign outstanding_o = w_count;
  assign orphan_err_o  = r_orphan;

  // Simulation-time sanity properties on the queue and the response channel.
  a_noPushWhenFull : assert property (@(posedge clk_i) disable iff (rst_i)
    w_push |-> !w_full);

  a_pStable : assert property (@(posedge clk_i) disable iff (rst_i)
    (r_pValid && !bus.p_ready_i) |=>
      (r_pValid && $stable(r_pData) && $stable(r_pError) && $stable(r_pId)));

  a_countBound : assert property (@(posedge clk_i) disable iff (rst_i)
    w_count <= CntWidth'(MaxOutstanding));

endmodule

// File: tb/tb_acc_c_responder.sv
// ---------------------------------------------------------------------------
// tb_acc_c_responder
// Directed bench for acc_c_responder. A model queue tracks accepted IDs; each
// core result pushes its expected response to a scoreboard, which is popped
// whenever the response channel completes a handshake.
// ---------------------------------------------------------------------------
module tb_acc_c_responder;
  import acc_pkg::*;

  localparam int DW = 32;
  localparam int IW = 2;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               core_req_valid_o;
  logic               core_req_ready_i;
  logic [31:0]        core_instr_o;
  logic [2:0][DW-1:0] core_rs_o;
  logic               core_rsp_valid_i;
  logic               core_rsp_ready_o;
  logic [DW-1:0]      core_rsp_data_i;
  logic               core_rsp_error_i;
  logic [CW-1:0]      outstanding_o;
  logic               orphan_err_o;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0]   idModel[$];
  acc_c_rsp_chan_t sbQueue[$];

  always #5 clk_i = ~clk_i;

  acc_c_responder_if #(.DataWidth(DW), .IdWidth(IW)) bus ();

  acc_c_responder #(
    .DataWidth      (DW),
    .IdWidth        (IW),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .bus              (bus),
    .core_req_valid_o (core_req_valid_o),
    .core_req_ready_i (core_req_ready_i),
    .core_instr_o     (core_instr_o),
    .core_rs_o        (core_rs_o),
    .core_rsp_valid_i (core_rsp_valid_i),
    .core_rsp_ready_o (core_rsp_ready_o),
    .core_rsp_data_i  (core_rsp_data_i),
    .core_rsp_error_i (core_rsp_error_i),
    .outstanding_o    (outstanding_o),
    .orphan_err_o     (orphan_err_o)
  );

  // Single comparison point: counts, asserts, reports.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: at the falling edge score any response handshake about to
  // complete, then return 1 time unit after the next rising edge.
  task automatic tick();
    acc_c_rsp_chan_t got;
    acc_c_rsp_chan_t exp;
    @(negedge clk_i);
    if (bus.p_valid_o === 1'b1 && bus.p_ready_i === 1'b1) begin
      got.data  = bus.p_data_o;
      got.error = bus.p_error_o;
      got.id    = bus.p_id_o;
      if (sbQueue.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL sb_unexpected_rsp observed=%0h expected=none", got);
      end else begin
        exp = sbQueue.pop_front();
        checkOutput("sb_rsp", 128'(got), 128'(exp));
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request with random payload and check the pass-through path.
  task automatic applyStimulus(input logic [IW-1:0] id);
    logic [31:0]        instr;
    logic [2:0][DW-1:0] rs;
    instr = $urandom;
    rs    = {$urandom, $urandom, $urandom};
    bus.q_valid_i = 1'b1;
    bus.q_id_i    = id;
    bus.q_instr_i = instr;
    bus.q_rs_i    = rs;
    #1;
    checkOutput("core_instr_pass", 128'(core_instr_o), 128'(instr));
    checkOutput("core_rs_pass", 128'(core_rs_o), 128'(rs));
    checkOutput("q_ready_accept", 128'(bus.q_ready_o), 128'(1));
    idModel.push_back(id);
    tick();
    bus.q_valid_i = 1'b0;
  endtask

  // Present one core result (left asserted for back-to-back use), wait for
  // acceptance, queue the expected response and check 1-cycle latency.
  task automatic coreRespond(input logic [DW-1:0] data, input logic err);
    acc_c_rsp_chan_t exp;
    int waitCycles;
    waitCycles       = 0;
    core_rsp_valid_i = 1'b1;
    core_rsp_data_i  = data;
    core_rsp_error_i = err;
    #1;
    while (core_rsp_ready_o !== 1'b1 && waitCycles < 50) begin
      tick();
      waitCycles++;
    end
    if (waitCycles >= 50) begin
      checks++;
      failures++;
      $error("[TB] FAIL core_rsp_ready_timeout observed=0 expected=1");
    end
    exp.data  = data;
    exp.error = err;
    exp.id    = (idModel.size() > 0) ? idModel.pop_front() : '0;
    sbQueue.push_back(exp);
    tick();
    checkOutput("p_valid_after_fire", 128'(bus.p_valid_o), 128'(1));
  endtask

  task automatic coreIdle();
    core_rsp_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i            = 1'b1;
    core_req_ready_i = 1'b1;
    core_rsp_valid_i = 1'b0;
    core_rsp_data_i  = '0;
    core_rsp_error_i = 1'b0;
    bus.q_valid_i    = 1'b0;
    bus.q_instr_i    = '0;
    bus.q_rs_i       = '0;
    bus.q_id_i       = '0;
    bus.p_ready_i    = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state
    checkOutput("rst_p_valid", 128'(bus.p_valid_o), 128'(0));
    checkOutput("rst_p_data", 128'(bus.p_data_o), 128'(0));
    checkOutput("rst_p_error", 128'(bus.p_error_o), 128'(0));
    checkOutput("rst_p_id", 128'(bus.p_id_o), 128'(0));
    checkOutput("rst_outstanding", 128'(outstanding_o), 128'(0));
    checkOutput("rst_orphan", 128'(orphan_err_o), 128'(0));

    // Single transaction
    $display("[TB] single transaction");
    applyStimulus(2'b11);
    checkOutput("single_outstanding_1", 128'(outstanding_o), 128'(1));
    tick();
    tick();
    checkOutput("single_p_idle", 128'(bus.p_valid_o), 128'(0));
    coreRespond(32'hDEADBEEF, 1'b0);
    checkOutput("single_p_data", 128'(bus.p_data_o), 128'(32'hDEADBEEF));
    checkOutput("single_p_id", 128'(bus.p_id_o), 128'(2'b11));
    checkOutput("single_outstanding_0", 128'(outstanding_o), 128'(0));
    coreIdle();
    checkOutput("single_p_fall", 128'(bus.p_valid_o), 128'(0));

    // Fill to depth, then drain back to back
    $display("[TB] fill");
    for (int i = 0; i < MO; i++) applyStimulus(IW'(i));
    checkOutput("fill_outstanding", 128'(outstanding_o), 128'(MO));
    bus.q_valid_i = 1'b1;
    bus.q_id_i    = '0;
    #1;
    checkOutput("fill_q_ready", 128'(bus.q_ready_o), 128'(0));
    checkOutput("fill_core_req_valid", 128'(core_req_valid_o), 128'(0));
    tick();
    bus.q_valid_i = 1'b0;
    checkOutput("fill_outstanding_hold", 128'(outstanding_o), 128'(MO));
    for (int i = 0; i < MO; i++) coreRespond(32'h1000 + DW'(i), 1'b0);
    coreIdle();
    checkOutput("fill_drained", 128'(outstanding_o), 128'(0));

    // Backpressure
    $display("[TB] backpressure");
    applyStimulus(2'd1);
    applyStimulus(2'd2);
    bus.p_ready_i = 1'b0;
    coreRespond(32'hA5A5_0001, 1'b1);
    core_rsp_data_i  = 32'hB6B6_0002;
    core_rsp_error_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_core_rsp_ready", 128'(core_rsp_ready_o), 128'(0));
      checkOutput("bp_p_valid", 128'(bus.p_valid_o), 128'(1));
      checkOutput("bp_p_data", 128'(bus.p_data_o), 128'(32'hA5A5_0001));
      checkOutput("bp_p_error", 128'(bus.p_error_o), 128'(1));
      checkOutput("bp_p_id", 128'(bus.p_id_o), 128'(2'd1));
      tick();
    end
    bus.p_ready_i = 1'b1;
    coreRespond(32'hB6B6_0002, 1'b0);
    checkOutput("bp_next_id", 128'(bus.p_id_o), 128'(2'd2));
    coreIdle();
    checkOutput("bp_outstanding", 128'(outstanding_o), 128'(0));

    // Simultaneous push and pop at two outstanding
    $display("[TB] simultaneous push/pop");
    applyStimulus(2'd0);
    applyStimulus(2'd1);
    checkOutput("sim_outstanding_pre", 128'(outstanding_o), 128'(2));
    begin
      acc_c_rsp_chan_t exp;
      bus.q_valid_i    = 1'b1;
      bus.q_id_i       = 2'd2;
      bus.q_instr_i    = $urandom;
      core_rsp_valid_i = 1'b1;
      core_rsp_data_i  = 32'hC0C0_C0C0;
      core_rsp_error_i = 1'b0;
      #1;
      checkOutput("sim_q_ready", 128'(bus.q_ready_o), 128'(1));
      checkOutput("sim_core_rsp_ready", 128'(core_rsp_ready_o), 128'(1));
      exp.data  = 32'hC0C0_C0C0;
      exp.error = 1'b0;
      exp.id    = idModel.pop_front();
      sbQueue.push_back(exp);
      idModel.push_back(2'd2);
      tick();
      bus.q_valid_i    = 1'b0;
      core_rsp_valid_i = 1'b0;
    end
    checkOutput("sim_outstanding_post", 128'(outstanding_o), 128'(2));
    checkOutput("sim_p_id_head", 128'(bus.p_id_o), 128'(2'd0));
    coreRespond(32'hC1C1_C1C1, 1'b1);
    coreRespond(32'hC2C2_C2C2, 1'b0);
    coreIdle();

    // Wrap pointers over ten more transactions
    for (int k = 0; k < 5; k++) begin
      applyStimulus(IW'($urandom_range(0, 3)));
      applyStimulus(IW'($urandom_range(0, 3)));
      coreRespond($urandom, 1'($urandom_range(0, 1)));
      coreRespond($urandom, 1'($urandom_range(0, 1)));
      coreIdle();
    end
    checkOutput("wrap_outstanding", 128'(outstanding_o), 128'(0));

    // Orphan result
    $display("[TB] orphan");
    core_rsp_valid_i = 1'b1;
    core_rsp_data_i  = 32'h0BAD_0BAD;
    #1;
    tick();
    core_rsp_valid_i = 1'b0;
    checkOutput("orphan_set", 128'(orphan_err_o), 128'(1));
    checkOutput("orphan_p_valid", 128'(bus.p_valid_o), 128'(0));
    checkOutput("orphan_outstanding", 128'(outstanding_o), 128'(0));
    tick();
    tick();
    tick();
    checkOutput("orphan_sticky", 128'(orphan_err_o), 128'(1));
    checkOutput("orphan_p_valid_later", 128'(bus.p_valid_o), 128'(0));

    // Reset in the middle of traffic
    $display("[TB] reset mid-operation");
    for (int i = 0; i < MO; i++) applyStimulus(IW'(3 - i));
    bus.p_ready_i = 1'b0;
    coreRespond(32'hFEED_0001, 1'b1);
    core_rsp_valid_i = 1'b0;
    checkOutput("midrst_outstanding_pre", 128'(outstanding_o), 128'(3));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    sbQueue.delete();
    idModel.delete();
    checkOutput("midrst_p_valid", 128'(bus.p_valid_o), 128'(0));
    checkOutput("midrst_p_data", 128'(bus.p_data_o), 128'(0));
    checkOutput("midrst_p_error", 128'(bus.p_error_o), 128'(0));
    checkOutput("midrst_p_id", 128'(bus.p_id_o), 128'(0));
    checkOutput("midrst_outstanding", 128'(outstanding_o), 128'(0));
    checkOutput("midrst_orphan", 128'(orphan_err_o), 128'(0));
    bus.p_ready_i = 1'b1;
    applyStimulus(2'd2);
    checkOutput("post_rst_outstanding", 128'(outstanding_o), 128'(1));
    coreRespond(32'h600D_600D, 1'b0);
    checkOutput("post_rst_p_id", 128'(bus.p_id_o), 128'(2'd2));
    coreIdle();
    checkOutput("post_rst_drained", 128'(outstanding_o), 128'(0));
    checkOutput("sb_drained", 128'(sbQueue.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
